// File: rtl/core_bus_pkg.sv
// Shared encodings for the core-side bus arbiters: grant codes, AXI response
// codes and the arbiter state type (state values double as GRANT codes).
package core_bus_pkg;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_DRD  = 2'd2;
  localparam logic [1:0] GNT_DWR  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = GNT_NONE,
    ST_IF_RD = GNT_IF,
    ST_D_RD  = GNT_DRD,
    ST_D_WR  = GNT_DWR
  } arb_state_t;

endpackage

// File: rtl/core_mem_arbiter.sv
// Two-master AXI4-Lite arbiter: ifetch reads and data reads/writes share one slave port.
// Masters hold their AR/AW VALID until the response; a falling VALID means flush.
module core_mem_arbiter
  import core_bus_pkg::*;
#(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    NRST,
  // ifetch read master
  input  logic [AXI_AWIDTH-1:0]   I_ARADDR,
  input  logic                    I_ARVALID,
  input  logic                    I_RREADY,
  output logic                    I_ARREADY,
  output logic [AXI_DWIDTH-1:0]   I_RDATA,
  output logic [1:0]              I_RRESP,
  output logic                    I_RVALID,
  // data master, read
  input  logic [AXI_AWIDTH-1:0]   D_ARADDR,
  input  logic                    D_ARVALID,
  input  logic                    D_RREADY,
  output logic                    D_ARREADY,
  output logic [AXI_DWIDTH-1:0]   D_RDATA,
  output logic [1:0]              D_RRESP,
  output logic                    D_RVALID,
  // data master, write
  input  logic [AXI_AWIDTH-1:0]   D_AWADDR,
  input  logic                    D_AWVALID,
  input  logic [AXI_DWIDTH-1:0]   D_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] D_WSTRB,
  input  logic                    D_WVALID,
  input  logic                    D_BREADY,
  output logic                    D_AWREADY,
  output logic                    D_WREADY,
  output logic [1:0]              D_BRESP,
  output logic                    D_BVALID,
  // shared slave port
  output logic [AXI_AWIDTH-1:0]   M_ARADDR,
  output logic                    M_ARVALID,
  output logic                    M_RREADY,
  input  logic                    M_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic [AXI_AWIDTH-1:0]   M_AWADDR,
  output logic                    M_AWVALID,
  output logic [AXI_DWIDTH-1:0]   M_WDATA,
  output logic [AXI_DWIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  output logic                    M_BREADY,
  input  logic                    M_AWREADY,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic [1:0]              GRANT
);

  arb_state_t state, state_nxt;
  logic last_if, last_if_nxt;
  logic addr_done, addr_done_nxt;
  logic w_done, w_done_nxt;
  logic drop_q, drop_nxt;
  logic gnt_vld, drop, addr_hs, w_hs, cpl;
  logic req_i, req_d;

  assign req_i = I_ARVALID;
  assign req_d = D_ARVALID | D_AWVALID;
  assign GRANT = state;

  // NOTE: every always_comb assigns all of its outputs first, so no path can infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    case (state)
      ST_IF_RD: gnt_vld = I_ARVALID;
      ST_D_RD:  gnt_vld = D_ARVALID;
      ST_D_WR:  gnt_vld = D_AWVALID;
      default:  gnt_vld = 1'b0;
    endcase
  end

  // Once the address is on the bus, a withdrawn request turns the rest of the
  // transaction into a silent drain of the response.
  assign drop = drop_q | (addr_done & ~gnt_vld);

  always_comb begin
    I_ARREADY = 1'b0;
    I_RDATA   = '0;
    I_RRESP   = '0;
    I_RVALID  = 1'b0;
    D_ARREADY = 1'b0;
    D_RDATA   = '0;
    D_RRESP   = '0;
    D_RVALID  = 1'b0;
    D_AWREADY = 1'b0;
    D_WREADY  = 1'b0;
    D_BRESP   = '0;
    D_BVALID  = 1'b0;
    M_ARADDR  = '0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    M_AWADDR  = '0;
    M_AWVALID = 1'b0;
    M_WDATA   = '0;
    M_WSTRB   = '0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    case (state)
      ST_IF_RD: begin
        M_ARADDR  = I_ARADDR;
        M_ARVALID = I_ARVALID & ~addr_done;
        I_ARREADY = M_ARREADY & ~addr_done;
        M_RREADY  = drop | I_RREADY;
        I_RVALID  = M_RVALID & ~drop;
        I_RDATA   = drop ? '0 : M_RDATA;
        I_RRESP   = drop ? '0 : M_RRESP;
      end
      ST_D_RD: begin
        M_ARADDR  = D_ARADDR;
        M_ARVALID = D_ARVALID & ~addr_done;
        D_ARREADY = M_ARREADY & ~addr_done;
        M_RREADY  = drop | D_RREADY;
        D_RVALID  = M_RVALID & ~drop;
        D_RDATA   = drop ? '0 : M_RDATA;
        D_RRESP   = drop ? '0 : M_RRESP;
      end
      ST_D_WR: begin
        M_AWADDR  = D_AWADDR;
        M_AWVALID = D_AWVALID & ~addr_done;
        D_AWREADY = M_AWREADY & ~addr_done;
        M_WDATA   = D_WDATA;
        M_WSTRB   = D_WSTRB;
        M_WVALID  = D_WVALID & ~w_done;
        D_WREADY  = M_WREADY & ~w_done;
        M_BREADY  = drop | D_BREADY;
        D_BVALID  = M_BVALID & ~drop;
        D_BRESP   = drop ? '0 : M_BRESP;
      end
      default: ;
    endcase
  end

  assign addr_hs = (M_ARVALID & M_ARREADY) | (M_AWVALID & M_AWREADY);
  assign w_hs    = M_WVALID & M_WREADY;
  assign cpl     = (M_RVALID & M_RREADY) | (M_BVALID & M_BREADY);

  always_comb begin
    state_nxt     = state;
    last_if_nxt   = last_if;
    addr_done_nxt = addr_done;
    w_done_nxt    = w_done;
    drop_nxt      = drop_q;
    if (state == ST_IDLE) begin
      addr_done_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      drop_nxt      = 1'b0;
      // Round-robin only matters on contention; a lone requester always wins.
      if (req_i && (!req_d || !last_if)) begin
        state_nxt   = ST_IF_RD;
        last_if_nxt = 1'b1;
      end else if (req_d) begin
        state_nxt   = D_AWVALID ? ST_D_WR : ST_D_RD;
        last_if_nxt = 1'b0;
      end
    end else begin
      if (addr_hs) addr_done_nxt = 1'b1;
      if (w_hs)    w_done_nxt    = 1'b1;
      if (drop)    drop_nxt      = 1'b1;
      if (cpl || (!addr_done && !gnt_vld)) begin
        state_nxt     = ST_IDLE;
        addr_done_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        drop_nxt      = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state     <= ST_IDLE;
      last_if   <= 1'b0;
      addr_done <= 1'b0;
      w_done    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_if   <= last_if_nxt;
      addr_done <= addr_done_nxt;
      w_done    <= w_done_nxt;
      drop_q    <= drop_nxt;
    end
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Arbitrates one AXI4-Lite slave port (unified memory/peripheral bus) between two masters: the instruction-fetch read channel (M0, read-only) and the data-memory load/store unit (M1, read + write). Sits between the core pipeline and the bus interconnect. Holds a grant for a whole transaction. Returns to IDLE on completion or on an abort before the address handshake.

Parameters:
AXI_AWIDTH, 4, address width of all ports
AXI_DWIDTH, 32, data width of all ports; write strobe width is AXI_DWIDTH/8

Ports:
CLK  in  1  clock
NRST  in  1  reset, synchronous, active-low
I_ARADDR/I_ARVALID/I_RREADY  in  AW/1/1  ifetch read request channel
I_ARREADY/I_RDATA/I_RRESP/I_RVALID  out  1/DW/2/1  ifetch read response channel
D_ARADDR/D_ARVALID/D_RREADY  in  AW/1/1  data read request channel
D_ARREADY/D_RDATA/D_RRESP/D_RVALID  out  1/DW/2/1  data read response channel
D_AWADDR/D_AWVALID/D_WDATA/D_WSTRB/D_WVALID/D_BREADY  in  AW/1/DW/DW/8/1/1  data write request channel
D_AWREADY/D_WREADY/D_BRESP/D_BVALID  out  1/1/2/1  data write response channel
M_ARADDR/M_ARVALID/M_RREADY  out  AW/1/1  shared-bus read request
M_ARREADY/M_RDATA/M_RRESP/M_RVALID  in  1/DW/2/1  shared-bus read response
M_AWADDR/M_AWVALID/M_WDATA/M_WSTRB/M_WVALID/M_BREADY  out  AW/1/DW/DW/8/1/1  shared-bus write request
M_AWREADY/M_WREADY/M_BRESP/M_BVALID  in  1/1/2/1  shared-bus write response
GRANT  out  2  current owner: 0=none, 1=ifetch read, 2=data read, 3=data write

Behaviour:
- State register: IDLE, IF_RD, D_RD, D_WR. Additional registers:
  - last_if: 1 bit, last granted requester was ifetch.
  - addr_done: 1 bit, address handshake completed in the current grant.
- Reset (NRST=0 at a CLK edge): state=IDLE, last_if=0, addr_done=0.
  - Consequence: all M_* VALID/READY outputs are 0, all I_*/D_* READY/VALID outputs are 0, GRANT=0.
  - Reset mid-transaction aborts silently. No drain is performed.
- Requests:
  - req_i = I_ARVALID.
  - req_d = D_ARVALID | D_AWVALID.
  - Within data, a write (D_AWVALID) beats a read.
- IDLE arbitration, registered. Grant takes effect the cycle after the request is seen (1-cycle arbitration latency):
  - Only one requester active -> grant it.
  - Both active -> round-robin: grant ifetch if last_if=0, else data. Update last_if on every grant.
- Granted state = combinational pass-through.
  - Granted master's signals connect to the M_* port; M_* ports of unused channels are driven 0.
  - Non-granted master sees READY=0 and VALID=0 on all its response signals.
  - RDATA/RRESP/BRESP are muxed to the granted master; non-granted masters see 0.
- Completion (next state IDLE):
  - IF_RD / D_RD: cycle with M_RVALID & M_RREADY.
  - D_WR: cycle with M_BVALID & M_BREADY.
  - Handshakes on AR and R in the same cycle are legal: the ifetch master completes on RVALID & ARREADY & ARVALID. Completion is then immediate.
- addr_done:
  - Set on M_ARVALID & M_ARREADY (reads) or M_AWVALID & M_AWREADY (writes).
  - Cleared on entering IDLE.
- Abort (ifetch FLUSH drops I_ARVALID):
  - If addr_done=0 and the granted VALID falls -> return to IDLE next cycle; nothing reaches the bus.
  - If addr_done=1 -> the arbiter holds the grant. It forces M_RREADY=1 (or M_BREADY=1) internally until the response arrives, then discards it: the master sees no VALID. Then it goes to IDLE.
- A request arriving in the same cycle as completion is arbitrated from IDLE on the next edge. Minimum back-to-back spacing: 1 idle cycle.
- No buffering; data width unchanged; no response reordering.

Decomposition:
- Shared package core_bus_pkg:
  - GRANT encodings (GNT_NONE/GNT_IF/GNT_DRD/GNT_DWR).
  - AXI RESP constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
  - State encodings.
- No sub-module needed. The round-robin picker is a small always block; optionally split it into core_rr_pick2 if reused by a future write-back arbiter.

Test Plan:
- Ifetch alone: I_ARADDR=4'h4, I_ARVALID=1, I_RREADY=1. Slave returns 32'h00000013 with ARREADY and RVALID in the same cycle, RRESP=0 -> GRANT=1 one cycle after the request; I_RVALID=1 with I_RDATA=32'h00000013 that cycle; GRANT=0 the next cycle.
- Simultaneous ifetch read and data read, last_if=0 -> ifetch granted first. After its R handshake, data is granted; D_RDATA=32'hDEADBEEF. last_if toggles each time.
- Data write, addr 4'h8, WDATA=32'h12345678, WSTRB=4'hF, BRESP=0 -> M_AW* and M_W* mirror the inputs; D_BVALID=1 for one cycle; I_ARREADY stays 0 throughout.
- Flush before AR handshake: I_ARVALID drops while M_ARREADY=0 -> state IDLE next cycle; M_ARVALID=0; no I_RVALID.
- Flush after AR handshake: slave delays RVALID 3 cycles -> M_RREADY=1 is held, I_RVALID stays 0, response is dropped; then a pending data read is granted.
- Reset asserted during D_WR -> GRANT=0 and all VALID/READY outputs are 0 at the next edge.
